// File: rtl/dc_offset_calibrator.sv
// DC offset calibrator: averages a 2^LOG2_WINDOW sample window and subtracts the
// resulting offset from every audio sample, saturating to 16 bits.
module dc_offset_calibrator #(
    parameter int LOG2_WINDOW = 10
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               audio_trigger,
    input  logic signed [15:0] signal_in,
    input  logic               cal_start,
    output logic signed [15:0] signal_out,
    output logic signed [15:0] offset_out,
    output logic               cal_busy,
    output logic               cal_done
);

    // state | meaning
    // IDLE  | pass-through, offset 0
    // CAL   | accumulating the calibration window
    // RUN   | correcting with the stored offset
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAL  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int ACC_W = 16 + LOG2_WINDOW;
    localparam logic [LOG2_WINDOW-1:0] CNT_MAX = '1;

    state_t                   state, state_nxt;
    logic signed [ACC_W-1:0]  acc, acc_nxt, acc_sum;
    logic [LOG2_WINDOW-1:0]   cnt, cnt_nxt;
    logic signed [15:0]       sout_nxt, off_nxt, sat_diff;
    logic signed [16:0]       diff;
    logic                     done_nxt;

    always_comb begin
        diff = {signal_in[15], signal_in} - {offset_out[15], offset_out};
        if (diff[16] != diff[15])
            sat_diff = diff[16] ? 16'sh8000 : 16'sh7fff;
        else
            sat_diff = diff[15:0];
    end

    // Window sum of 2^LOG2_WINDOW 16-bit samples always fits in ACC_W bits.
    assign acc_sum = acc + {{LOG2_WINDOW{signal_in[15]}}, signal_in};

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        off_nxt   = offset_out;
        sout_nxt  = signal_out;
        done_nxt  = 1'b0;

        if (audio_trigger)
            sout_nxt = sat_diff;

        case (state)
            IDLE: begin
                off_nxt = '0;
                if (cal_start) begin
                    state_nxt = CAL;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (cal_start) begin
                    state_nxt = CAL;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            CAL: begin
                if (audio_trigger) begin
                    acc_nxt = acc_sum;
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CNT_MAX) begin
                        // Upper bits of the sum are the floor-divided mean.
                        off_nxt   = acc_sum[LOG2_WINDOW+15:LOG2_WINDOW];
                        done_nxt  = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            offset_out <= '0;
            signal_out <= '0;
            cal_done   <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            cnt        <= cnt_nxt;
            offset_out <= off_nxt;
            signal_out <= sout_nxt;
            cal_done   <= done_nxt;
        end
    end

    assign cal_busy = (state == CAL);

endmodule

// File: tb/tb_dc_offset_calibrator.sv
// Bench for dc_offset_calibrator with LOG2_WINDOW=2: directed scenarios with literal
// expectations plus a per-cycle comparison against a sample-queue model.
module tb_dc_offset_calibrator;

    localparam int L   = 2;
    localparam int WIN = 1 << L;

    logic               clk_in = 1'b0;
    logic               rst_n_in;
    logic               audio_trigger;
    logic signed [15:0] signal_in;
    logic               cal_start;
    logic signed [15:0] signal_out;
    logic signed [15:0] offset_out;
    logic               cal_busy;
    logic               cal_done;

    int n_checks = 0;
    int n_pass   = 0;

    dc_offset_calibrator #(.LOG2_WINDOW(L)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .audio_trigger (audio_trigger),
        .signal_in     (signal_in),
        .cal_start     (cal_start),
        .signal_out    (signal_out),
        .offset_out    (offset_out),
        .cal_busy      (cal_busy),
        .cal_done      (cal_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int floor_div(input int num, input int den);
        int r;
        r = ((num % den) + den) % den;
        return (num - r) / den;
    endfunction

    // Model: offset in use, calibration flag, and the samples collected so far.
    int m_out, m_off, m_done;
    bit m_active;
    int m_q[$];

    always @(posedge clk_in) begin
        int sv, sum;
        sv = int'(signal_in);
        if (!rst_n_in) begin
            m_out = 0; m_off = 0; m_done = 0; m_active = 0;
            m_q.delete();
        end else begin
            m_done = 0;
            if (audio_trigger) m_out = sat16(sv - m_off);
            if (m_active) begin
                if (audio_trigger) begin
                    m_q.push_back(sv);
                    if (m_q.size() == WIN) begin
                        sum = 0;
                        foreach (m_q[i]) sum += m_q[i];
                        m_off    = floor_div(sum, WIN);
                        m_active = 0;
                        m_done   = 1;
                    end
                end
            end else if (cal_start) begin
                m_active = 1;
                m_q.delete();
            end
        end
        #1;
        check("cmp_signal_out", int'(signal_out), m_out);
        check("cmp_offset_out", int'(offset_out), m_off);
        check("cmp_cal_busy",   int'(cal_busy),   int'(m_active));
        check("cmp_cal_done",   int'(cal_done),   m_done);
    end

    // All drive tasks start and end on a falling edge.
    task automatic trig(input int v);
        audio_trigger = 1'b1;
        signal_in     = 16'(v);
        @(negedge clk_in);
        audio_trigger = 1'b0;
    endtask

    task automatic start_cal(input bit with_trig, input int v);
        cal_start     = 1'b1;
        audio_trigger = with_trig;
        signal_in     = 16'(v);
        @(negedge clk_in);
        cal_start     = 1'b0;
        audio_trigger = 1'b0;
    endtask

    task automatic calibrate(input int a, input int b, input int c, input int d, input string tag);
        start_cal(1'b0, 0);
        check({tag, "_busy_enter"}, int'(cal_busy), 1);
        trig(a); trig(b); trig(c);
        check({tag, "_busy_mid"}, int'(cal_busy), 1);
        trig(d);
        check({tag, "_done_pulse"}, int'(cal_done), 1);
        check({tag, "_busy_after"}, int'(cal_busy), 0);
        @(negedge clk_in);
        check({tag, "_done_once"}, int'(cal_done), 0);
    endtask

    initial begin
        rst_n_in      = 1'b0;
        audio_trigger = 1'b0;
        signal_in     = '0;
        cal_start     = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_signal_out", int'(signal_out), 0);
        check("rst_offset_out", int'(offset_out), 0);
        check("rst_busy", int'(cal_busy), 0);
        check("rst_done", int'(cal_done), 0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        trig(1000);
        check("pass_signal_out", int'(signal_out), 1000);
        check("pass_offset", int'(offset_out), 0);
        check("pass_busy", int'(cal_busy), 0);

        calibrate(100, 102, 98, 104, "basic");
        check("basic_offset", int'(offset_out), 101);
        trig(200);
        check("basic_corrected", int'(signal_out), 99);

        calibrate(-1, -1, -1, -2, "neg");
        check("neg_offset", int'(offset_out), -2);
        trig(0);
        check("neg_corrected", int'(signal_out), 2);

        calibrate(-30000, -30000, -30000, -30000, "satp");
        check("satp_offset", int'(offset_out), -30000);
        trig(10000);
        check("satp_corrected", int'(signal_out), 32767);

        calibrate(30000, 30000, 30000, 30000, "satn");
        check("satn_offset", int'(offset_out), 30000);
        trig(-10000);
        check("satn_corrected", int'(signal_out), -32768);

        // Trigger alongside cal_start is corrected with the old offset, not accumulated.
        start_cal(1'b1, 1000);
        check("restart_same_cycle_out", int'(signal_out), -29000);
        check("restart_old_offset", int'(offset_out), 30000);
        trig(10); trig(20);
        start_cal(1'b0, 0);
        check("restart_ignored_busy", int'(cal_busy), 1);
        trig(30);
        check("restart_not_done_early", int'(cal_done), 0);
        trig(44);
        check("restart_done", int'(cal_done), 1);
        check("restart_offset", int'(offset_out), 26);
        @(negedge clk_in);

        start_cal(1'b0, 0);
        trig(5); trig(6);
        #2 rst_n_in = 1'b0;
        #1;
        check("midrst_signal_out", int'(signal_out), 0);
        check("midrst_offset", int'(offset_out), 0);
        check("midrst_busy", int'(cal_busy), 0);
        check("midrst_done", int'(cal_done), 0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        trig(7); trig(8);
        check("midrst_no_done", int'(cal_done), 0);
        check("midrst_pass", int'(signal_out), 8);
        check("midrst_idle_busy", int'(cal_busy), 0);
        repeat (3) @(negedge clk_in);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
